// File: rtl/countdown_timer.sv
// Loadable down-counter: IDLE/RUN/DONE FSM with registered busy/expired and a one-cycle done pulse.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN for periodic operation (reload on zero, stay in RUN).
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             stop,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic             busy_q;
  logic             expired_q;
  logic             done_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      value_q   <= ZERO;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= ZERO;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        // Load wins over stop and enable; a zero load expires immediately.
        value_q <= load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_q <= load_value;
`endif
        if (load_value != ZERO) begin
          state_q   <= RUN;
          busy_q    <= 1'b1;
          expired_q <= 1'b0;
        end else begin
          state_q   <= DONE;
          busy_q    <= 1'b0;
          expired_q <= 1'b1;
          done_q    <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (enable) begin
              if (value_q > ONE) begin
                value_q <= value_q - ONE;
              end else begin
                done_q <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                if (reload_q != ZERO) begin
                  value_q <= reload_q;
                end else begin
                  value_q   <= ZERO;
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  expired_q <= 1'b1;
                end
`else
                value_q   <= ZERO;
                state_q   <= DONE;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
`endif
              end
            end
          end
          // IDLE and DONE ignore enable/stop and hold everything until a load.
          IDLE:    state_q <= IDLE;
          DONE:    state_q <= DONE;
          default: begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value   = value_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; reload-specific sequence runs when COUNTDOWN_TIMER_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       stop;
  logic [7:0] value;
  logic       busy;
  logic       expired;
  logic       done;

  int checks;
  int errors;

  countdown_timer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .stop       (stop),
    .value      (value),
    .busy       (busy),
    .expired    (expired),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] v, input logic b,
                         input logic e, input logic d);
    chk({tag, ".value"},   {24'd0, value}, {24'd0, v});
    chk({tag, ".busy"},    {31'd0, busy},    {31'd0, b});
    chk({tag, ".expired"}, {31'd0, expired}, {31'd0, e});
    chk({tag, ".done"},    {31'd0, done},    {31'd0, d});
  endtask

  logic [7:0] exp_vals [0:6];
  int         done_cnt;

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b1;
    load       = 1'b0;
    load_value = 8'd0;
    enable     = 1'b0;
    stop       = 1'b0;

    #2 reset_n = 1'b0;
    #1 chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    // Release with load already high: the first edge with reset_n=1 takes it.
    load = 1'b1; load_value = 8'd7;
    reset_n = 1'b1;
    step();
    chk_all("first_edge_load", 8'd7, 1'b1, 1'b0, 1'b0);

    // Reset mid-count.
    load = 1'b1; load_value = 8'd5; enable = 1'b0;
    step();
    chk_all("rst_load5", 8'd5, 1'b1, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b1;
    step();
    step();
    chk_all("rst_cnt3", 8'd3, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_all("rst_async", 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk_all("rst_idle", 8'd0, 1'b0, 1'b0, 1'b0);

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // Load 3, enable held.
    load = 1'b1; load_value = 8'd3; enable = 1'b1;
    step();
    chk_all("l3_a", 8'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("l3_b", 8'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("l3_c", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("l3_zero", 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("l3_hold", 8'd0, 1'b0, 1'b1, 1'b0);

    // Load 4, enable toggling.
    exp_vals[0] = 8'd3; exp_vals[1] = 8'd3; exp_vals[2] = 8'd2; exp_vals[3] = 8'd2;
    exp_vals[4] = 8'd1; exp_vals[5] = 8'd1; exp_vals[6] = 8'd0;
    load = 1'b1; load_value = 8'd4; enable = 1'b1;
    step();
    chk_all("l4_load", 8'd4, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      enable = (i % 2 == 0);
      step();
      chk({"l4_val"}, {24'd0, value}, {24'd0, exp_vals[i]});
      if (done) done_cnt++;
    end
    chk("l4_expired", {31'd0, expired}, 32'd1);
    enable = 1'b1;
    step();
    if (done) done_cnt++;
    chk("l4_done_cnt", done_cnt, 32'd1);
`else
    // Periodic reload: load 2, enable held.
    load = 1'b1; load_value = 8'd2; enable = 1'b1;
    step();
    chk_all("ar_load", 8'd2, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("ar_1a", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("ar_rel_a", 8'd2, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("ar_1b", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("ar_rel_b", 8'd2, 1'b1, 1'b0, 1'b1);
`endif

    // Stop, then load with stop on the same edge.
    load = 1'b1; load_value = 8'd10; enable = 1'b1; stop = 1'b0;
    step();
    chk_all("l10_load", 8'd10, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    step();
    chk_all("l10_cnt8", 8'd8, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    chk_all("stop_idle", 8'd8, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("idle_hold", 8'd8, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_value = 8'd6;
    step();
    chk_all("load_over_stop", 8'd6, 1'b1, 1'b0, 1'b0);
    load = 1'b0; stop = 1'b0;
    step();
    chk_all("l6_dec", 8'd5, 1'b1, 1'b0, 1'b0);

    // Load 0 goes straight to DONE; enable/stop then have no effect.
    load = 1'b1; load_value = 8'd0; enable = 1'b0;
    step();
    chk_all("l0", 8'd0, 1'b0, 1'b1, 1'b1);
    load = 1'b0; enable = 1'b1;
    step();
    chk_all("l0_done_once", 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 254; i++) step();
    stop = 1'b1;
    step();
    chk_all("l0_255", 8'd0, 1'b0, 1'b1, 1'b0);
    stop = 1'b0; enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  load load_value and start counting.
REQ-005 load_value  input  WIDTH  start count, sampled only when load=1.
REQ-006 enable  input  1  decrement permit for the current cycle.
REQ-007 stop  input  1  abort the current count.
REQ-008 value  output  WIDTH  registered current count.
REQ-009 busy  output  1  registered; 1 iff state RUN.
REQ-010 expired  output  1  registered; 1 iff state DONE.
REQ-011 done  output  1  registered one-cycle pulse on reaching zero.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; all outputs are registered and update only on the rising edge of clk.
REQ-013 load=1 in any state SHALL set value=load_value and store load_value as the reload value. The next state SHALL be RUN if load_value!=0, else DONE with done=1 on the following cycle.
REQ-014 In RUN with enable=1 and value>1, value SHALL decrement by 1 per cycle.
REQ-015 In RUN with enable=1 and value==1, the next cycle SHALL show value=0, done=1, state DONE (one-cycle latency).
REQ-016 In RUN with enable=0, value and state SHALL hold.
REQ-017 stop=1 in RUN (load=0) SHALL move the FSM to IDLE with value held at its current count and done=0.
REQ-018 Priority SHALL be load > stop > enable. Load in a given cycle suppresses both decrement and abort.
REQ-019 In IDLE and DONE, enable and stop SHALL be ignored. value SHALL hold, and DONE SHALL persist until load.
REQ-020 done SHALL be 1 for exactly one cycle per zero arrival, never 1 in two consecutive cycles, and 0 otherwise.
REQ-021 value SHALL never wrap below 0 in non-reload builds.

Reset
REQ-022 While reset_n=0, asynchronously: state=IDLE, value=0, reload value=0, busy=0, expired=0, done=0.
REQ-023 Reset asserted mid-count SHALL discard the count. After deassertion the block SHALL sit in IDLE until load.
REQ-024 Reset deassertion SHALL take effect on the first clk edge with reset_n=1; no load is accepted on that edge's predecessor.

Configuration
REQ-025 Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN SHALL control periodic operation.
- Defined: at a zero arrival with a nonzero reload value, value reloads to the reload value the same cycle done=1, and the FSM stays RUN; DONE is reachable only via load of 0.
- Undefined: behaviour per REQ-015 and REQ-019, and the reload register MAY be removed.

Verification
REQ-026 Reset mid-count:
- Stimulus: load 5, two enabled cycles, pulse reset_n low asynchronously.
- Required response: value=0, busy=0, expired=0, done=0 immediately, without waiting for a clock edge.
REQ-027 Load 3 with enable held at 1:
- Values 3,2,1,0.
- done=1 only in the cycle value first reads 0; then expired=1, busy=0.
REQ-028 Load 4, enable toggling 1,0,1,0,...:
- Values 4,3,3,2,2,1,1,0.
- done pulse once.
REQ-029 Load 10, after 2 enabled cycles (value 8):
- Assert stop with enable=1: IDLE, value=8.
- Assert load 6 with stop=1 on the same edge: RUN, value=6.
REQ-030 Load 0:
- expired=1 and done=1 one cycle after the load edge; value=0.
- 255 enable cycles in DONE leave value=0.
REQ-031 With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, load 2 with enable held at 1:
- Values 2,1,2,1,2,...
- done=1 at each reload cycle; busy stays 1.
